// File: rtl/dnn_mem_loader_fix.sv
// dnn_mem_loader_fix: framed byte-stream writer for the shared parameter memory.
// Frame: LEN_H, LEN_L, ADDR_H, ADDR_L, LEN data bytes, [CSUM].
// Optional feature macro: LOADER_CSUM_EN (trailing XOR checksum byte and CSUM state).
//
// state  | meaning
// IDLE   | waiting for LEN_H
// LEN_L  | waiting for LEN low byte
// ADDR_H | waiting for ADDR high byte
// ADDR_L | waiting for ADDR low byte, bounds check runs on accept
// DATA   | one memory write per accepted byte
// SKIP   | out-of-range frame, payload is drained without writes
// CSUM   | waiting for checksum byte (LOADER_CSUM_EN only)
module dnn_mem_loader_fix #(
  parameter int          DATA_WIDTH = 5,
  parameter int          ADDR_WIDTH = 16,
  parameter logic [15:0] MEM_DEPTH  = 16'h29FE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         busy,
  output logic                         load_done,
  output logic                         load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_L, S_ADDR_H, S_ADDR_L, S_DATA, S_SKIP
`ifdef LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t                         state_q, state_d;
  logic [15:0]                    len_q, len_d;
  logic [15:0]                    addr_q, addr_d;
  logic [15:0]                    cnt_q, cnt_d;
  logic [7:0]                     csum_q, csum_d;
  logic                           wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]          wr_addr_q, wr_addr_d;
  logic signed [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                           done_q, done_d;
  logic                           err_q, err_d;
`ifdef LOADER_CSUM_EN
  logic                           bad_q, bad_d;
`endif

  logic [15:0] addr_full;
  logic [16:0] end_sum;
  logic        oob;
  logic        acc;

  // The 17-bit sum cannot wrap, so a frame that runs past 0xFFFF is still rejected.
  assign acc       = in_valid;
  assign addr_full = {addr_q[15:8], in_data};
  assign end_sum   = {1'b0, addr_full} + {1'b0, len_q};
  assign oob       = end_sum > {1'b0, MEM_DEPTH};

  // Next-state, datapath and pulse generation.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef LOADER_CSUM_EN
    bad_d     = bad_q;
`endif
    if (acc) begin
      case (state_q)
        S_IDLE: begin
          len_d   = {in_data, 8'h00};
          csum_d  = 8'h00;
`ifdef LOADER_CSUM_EN
          bad_d   = 1'b0;
`endif
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          len_d   = {len_q[15:8], in_data};
          state_d = S_ADDR_H;
        end
        S_ADDR_H: begin
          addr_d  = {in_data, 8'h00};
          state_d = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_d = addr_full;
          cnt_d  = len_q;
`ifdef LOADER_CSUM_EN
          bad_d  = oob;
`endif
          if (len_q != 16'd0) begin
            state_d = oob ? S_SKIP : S_DATA;
          end else begin
`ifdef LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
            done_d  = ~oob;
            err_d   = oob;
`endif
          end
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_WIDTH'(addr_q);
          wr_data_d = $signed(in_data[DATA_WIDTH-1:0]);
          addr_d    = addr_q + 16'd1;
          csum_d    = csum_q ^ in_data;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
`ifdef LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
        S_SKIP: begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
`ifdef LOADER_CSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_IDLE;
            err_d   = 1'b1;
`endif
          end
        end
`ifdef LOADER_CSUM_EN
        S_CSUM: begin
          state_d = S_IDLE;
          if (bad_q || (in_data != csum_q)) err_d = 1'b1;
          else                              done_d = 1'b1;
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset abandons any partial frame silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      csum_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef LOADER_CSUM_EN
      bad_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef LOADER_CSUM_EN
      bad_q     <= bad_d;
`endif
    end
  end

  assign in_ready  = 1'b1;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = (state_q != S_IDLE);
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_dnn_mem_loader_fix.sv
// Bench for dnn_mem_loader_fix: directed frames, a queue-based model of
// expected writes/pulses (tagged with the cycle they must appear), and
// hand-computed literal checks that pin the model.
module tb_dnn_mem_loader_fix;
  localparam int MEM_DEPTH_I = 'h29FE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [15:0]       wr_addr;
  logic signed [4:0] wr_data;
  logic              busy;
  logic              load_done;
  logic              load_err;

  dnn_mem_loader_fix dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [15:0] a; logic [4:0] d; } wr_t;
  typedef struct { int cyc; bit ok; } pl_t;
  wr_t wq[$];
  pl_t pq[$];

  int n_chk = 0, n_pass = 0;
  int n_wr = 0, n_done = 0, n_err = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0;
  logic [15:0] last_a = 0;
  logic [4:0]  last_d = 0;
  logic [7:0]  last_x = 0;
  logic [7:0]  dbuf [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Compare process: every cycle outside reset, match DUT activity to the model queues.
  always @(negedge clk) begin
    wr_t w;
    pl_t p;
    if (!rst) begin
      check("in_ready", {31'b0, in_ready}, 32'd1);
      if (wr_en) begin
        if (n_wr == 0 || last_wr_cyc != cyc - 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        n_wr++;
        last_a = wr_addr;
        last_d = wr_data;
        if (wq.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          w = wq.pop_front();
          check("wr_cycle", cyc, w.cyc);
          check("wr_addr", {16'b0, wr_addr}, {16'b0, w.a});
          check("wr_data", {27'b0, wr_data}, {27'b0, w.d});
        end
      end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
        w = wq.pop_front();
        check("missing_write", 32'd0, 32'd1);
      end
      if (load_done || load_err) begin
        if (load_done) n_done++;
        if (load_err)  n_err++;
        check("pulse_exclusive", {31'b0, load_done & load_err}, 32'd0);
        if (pq.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
        else begin
          p = pq.pop_front();
          check("pulse_cycle", cyc, p.cyc);
          check("pulse_kind", {30'b0, load_done, load_err}, p.ok ? 32'd2 : 32'd1);
          check("busy_at_pulse", {31'b0, busy}, 32'd0);
        end
      end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
        p = pq.pop_front();
        check("missing_pulse", 32'd0, 32'd1);
      end
    end
  end

  task automatic put_byte(input logic [7:0] b, input bit gap, output int acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    acc      = cyc + 1;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Model: frame accepted iff addr+len fits; writes follow each data byte by one cycle.
  task automatic send_frame(input int len, input int addr, input logic [7:0] cs, input bit gap);
    int acc;
    bit pass;
    logic [7:0] x;
    logic [15:0] l16, a16;
    l16 = len[15:0];
    a16 = addr[15:0];
    pass = (addr + len) <= MEM_DEPTH_I;
    x = 8'h00;
    put_byte(l16[15:8], gap, acc);
    put_byte(l16[7:0],  gap, acc);
    put_byte(a16[15:8], gap, acc);
    put_byte(a16[7:0],  gap, acc);
    for (int i = 0; i < len; i++) begin
      put_byte(dbuf[i], gap, acc);
      x = x ^ dbuf[i];
      if (pass) wq.push_back('{acc, 16'(addr + i), dbuf[i][4:0]});
    end
    last_x = x;
`ifdef LOADER_CSUM_EN
    put_byte(cs, gap, acc);
    pq.push_back('{acc, pass && (cs == x)});
`else
    pq.push_back('{acc, pass});
`endif
    idle();
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (wq.size() > 0 || pq.size() > 0); i++) @(negedge clk);
    check("drain_writes", wq.size(), 32'd0);
    check("drain_pulses", pq.size(), 32'd0);
    wq.delete();
    pq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wr_en"},   {31'b0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, {16'b0, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, {27'b0, wr_data}, 32'd0);
    check({tag, "_busy"},    {31'b0, busy}, 32'd0);
    check({tag, "_done"},    {31'b0, load_done}, 32'd0);
    check({tag, "_err"},     {31'b0, load_err}, 32'd0);
    check({tag, "_ready"},   {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, d0, e0, acc;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal 3-word frame with correct checksum.
    dbuf[0] = 8'h05; dbuf[1] = 8'h1F; dbuf[2] = 8'hE8;
    w0 = n_wr; d0 = n_done; e0 = n_err;
    send_frame(3, 'h0191, 8'hF2, 1'b0);
    drain();
    check("t1_xor", {24'b0, last_x}, 32'hF2);
    check("t1_nwr", n_wr - w0, 32'd3);
    check("t1_consec", last_wr_cyc - first_wr_cyc, 32'd2);
    check("t1_last_addr", {16'b0, last_a}, 32'h0193);
    check("t1_last_data", {27'b0, last_d}, 32'h08);
    check("t1_done", n_done - d0, 32'd1);
    check("t1_err", n_err - e0, 32'd0);

`ifdef LOADER_CSUM_EN
    // Same frame, wrong checksum: writes stay, error reported.
    w0 = n_wr; d0 = n_done; e0 = n_err;
    send_frame(3, 'h0191, 8'h00, 1'b0);
    drain();
    check("t2_nwr", n_wr - w0, 32'd3);
    check("t2_done", n_done - d0, 32'd0);
    check("t2_err", n_err - e0, 32'd1);
`endif

    // Out of range at the top of memory, then the last word exactly.
    dbuf[0] = 8'hAA; dbuf[1] = 8'h55;
    w0 = n_wr; d0 = n_done; e0 = n_err;
    send_frame(2, 'h29FD, 8'hFF, 1'b0);
    drain();
    check("t3_nwr", n_wr - w0, 32'd0);
    check("t3_err", n_err - e0, 32'd1);
    dbuf[0] = 8'h13;
    w0 = n_wr; d0 = n_done;
    send_frame(1, 'h29FD, 8'h13, 1'b0);
    drain();
    check("t4_nwr", n_wr - w0, 32'd1);
    check("t4_addr", {16'b0, last_a}, 32'h29FD);
    check("t4_data", {27'b0, last_d}, 32'h13);
    check("t4_done", n_done - d0, 32'd1);

    // Empty frame.
    w0 = n_wr; d0 = n_done;
    send_frame(0, 'h0000, 8'h00, 1'b0);
    drain();
    check("t5_nwr", n_wr - w0, 32'd0);
    check("t5_done", n_done - d0, 32'd1);

    // Stalled stream: valid every other cycle.
    dbuf[0] = 8'h01; dbuf[1] = 8'h02; dbuf[2] = 8'h03; dbuf[3] = 8'h04;
    w0 = n_wr; d0 = n_done;
    send_frame(4, 'h0100, 8'h04, 1'b1);
    drain();
    check("t6_xor", {24'b0, last_x}, 32'h04);
    check("t6_nwr", n_wr - w0, 32'd4);
    check("t6_last_addr", {16'b0, last_a}, 32'h0103);
    check("t6_done", n_done - d0, 32'd1);

    // Reset after the second of four data bytes.
    w0 = n_wr; d0 = n_done; e0 = n_err;
    put_byte(8'h00, 1'b0, acc);
    put_byte(8'h04, 1'b0, acc);
    put_byte(8'h02, 1'b0, acc);
    put_byte(8'h00, 1'b0, acc);
    put_byte(8'h09, 1'b0, acc);
    wq.push_back('{acc, 16'h0200, 5'h09});
    put_byte(8'h0A, 1'b0, acc);
    wq.push_back('{acc, 16'h0201, 5'h0A});
    idle();
    check("t7_busy_mid", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    check("t7_nwr", n_wr - w0, 32'd2);
    repeat (3) @(negedge clk);
    check("t7_no_pulse", (n_done - d0) + (n_err - e0), 32'd0);

    // Fresh frame after the abort.
    dbuf[0] = 8'h7F; dbuf[1] = 8'h80;
    w0 = n_wr; d0 = n_done;
    send_frame(2, 'h0300, 8'hFF, 1'b0);
    drain();
    check("t8_nwr", n_wr - w0, 32'd2);
    check("t8_last_addr", {16'b0, last_a}, 32'h0301);
    check("t8_last_data", {27'b0, last_d}, 32'h00);
    check("t8_done", n_done - d0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
